clk_div_sched: RTL

Runtime-programmable clock-divider controller: generates a divided clock `o_clk` from `i_clk` and owns enable/disable sequencing and divisor reconfiguration. Divisor updates arrive over a valid/ready handshake and take effect only at a full-period boundary (`o_clk` falling edge). Stops always leave `o_clk` low, with no runt pulses. It sits between the system configuration logic and every consumer of a divided clock or tick.

---
 rtl/clk_div_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// Runtime-programmable clock divider: o_clk half-period = active divisor cycles of i_clk.
// Divisor updates are accepted over valid/ready and applied only at o_clk falling boundaries.
module clk_div_sched #(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 50
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_cfg_valid,
   input  logic [CNT_W-1:0] i_cfg_div,
   output logic             o_cfg_ready,
   output logic             o_cfg_err,
   output logic             o_clk,
   output logic             o_rise,
   output logic             o_running
);

   localparam logic [CNT_W-1:0] DEF  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO = '0;

   typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             err_q, err_d;

   logic             ready;
   logic             accept;
   logic             toggle;
   logic [CNT_W-1:0] cfg_clamped;
   logic [CNT_W-1:0] cnt_inc;

   assign ready       = (state_q == IDLE) || (state_q == RUN);
   assign accept      = i_cfg_valid && ready;
   assign cfg_clamped = (i_cfg_div == ZERO) ? ONE : i_cfg_div;
   // >= rather than == so a shrinking divisor can never let the counter run past the limit
   assign toggle      = (cnt_q >= (div_q - ONE));
   assign cnt_inc     = toggle ? ZERO : (cnt_q + ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      rise_d  = 1'b0;
      err_d   = accept && (i_cfg_div == ZERO);

      case (state_q)
         IDLE: begin
            cnt_d = ZERO;
            clk_d = 1'b0;
            if (accept) begin
               div_d  = cfg_clamped;
               pend_d = cfg_clamped;
            end
            if (i_en) state_d = RUN;
         end
         RUN: begin
            if (accept) pend_d = cfg_clamped;
            if (!i_en && (!clk_q || toggle)) begin
               state_d = IDLE;
               cnt_d   = ZERO;
               clk_d   = 1'b0;
               if (accept) div_d = cfg_clamped;
            end else if (!i_en) begin
               state_d = STOP;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
               if (toggle) begin
                  clk_d  = ~clk_q;
                  rise_d = ~clk_q;
               end
               if (accept) state_d = PEND;
            end
         end
         PEND: begin
            if (!i_en && (!clk_q || toggle)) begin
               state_d = IDLE;
               cnt_d   = ZERO;
               clk_d   = 1'b0;
               div_d   = pend_q;
            end else if (!i_en) begin
               state_d = STOP;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
               if (toggle) begin
                  clk_d  = ~clk_q;
                  rise_d = ~clk_q;
                  if (clk_q) begin
                     div_d   = pend_q;
                     state_d = RUN;
                  end
               end
            end
         end
         STOP: begin
            // pend_q mirrors div_q unless an update is outstanding, so applying it is always safe
            if (toggle) begin
               state_d = IDLE;
               cnt_d   = ZERO;
               clk_d   = 1'b0;
               div_d   = pend_q;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= ZERO;
         div_q   <= DEF;
         pend_q  <= DEF;
         clk_q   <= 1'b0;
         rise_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         rise_q  <= rise_d;
         err_q   <= err_d;
      end
   end

   assign o_cfg_ready = ready;
   assign o_cfg_err   = err_q;
   assign o_clk       = clk_q;
   assign o_rise      = rise_q;
   assign o_running   = (state_q != IDLE);

endmodule
